// File: rtl/unidad_busqueda_pkg.sv
// unidad_busqueda_pkg: definitions shared by the fetch unit and the control unit.
//   - default widths for the program counter and the instruction word
//   - opcode field position and width
//   - halt opcode pattern with its compare mask (bits [1:0] are don't-care)
//   - fetch FSM state encoding
package unidad_busqueda_pkg;

    localparam int unsigned ANCHO_PC_DEF    = 10;
    localparam int unsigned ANCHO_INSTR_DEF = 16;

    // The opcode occupies the top ANCHO_OPCODE bits of the instruction word.
    localparam int unsigned ANCHO_OPCODE = 6;

    // Halt pattern 1110??: the mask selects the bits that take part in the compare.
    localparam logic [ANCHO_OPCODE-1:0] OPCODE_PARADA_DEF  = 6'b111000;
    localparam logic [ANCHO_OPCODE-1:0] MASCARA_PARADA_DEF = 6'b111100;

    typedef enum logic [1:0] {
        PEDIR    = 2'd0,
        ESPERAR  = 2'd1,
        ENTREGAR = 2'd2,
        PARADO   = 2'd3
    } estado_e;

    function automatic logic es_parada(input logic [ANCHO_OPCODE-1:0] op,
                                       input logic [ANCHO_OPCODE-1:0] patron,
                                       input logic [ANCHO_OPCODE-1:0] mascara);
        return ((op ^ patron) & mascara) == '0;
    endfunction

endpackage

// File: rtl/unidad_busqueda_contador_pc.sv
// contador_pc: program counter register.
//   reloj    in   clock, rising edge
//   reset    in   synchronous active-high reset, clears the counter
//   en_i     in   update enable
//   cargar_i in   1 = load dir_i, 0 = increment (wraps modulo 2^ANCHO)
//   dir_i    in   load value
//   pc_o     out  current counter value
module contador_pc #(
    parameter int unsigned ANCHO = 10
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             en_i,
    input  logic             cargar_i,
    input  logic [ANCHO-1:0] dir_i,
    output logic [ANCHO-1:0] pc_o
);

    logic [ANCHO-1:0] pc_q;

    always_ff @(posedge reloj) begin
        if (reset) begin
            pc_q <= '0;
        end else if (en_i) begin
            pc_q <= cargar_i ? dir_i : pc_q + ANCHO'(1);
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction fetch unit.
// Requests the word at pc, captures it on mem_ack, presents it to the control
// unit until consumed, then either advances pc (pc+1 or jump target) or stops
// permanently when the opcode matches the halt pattern.
//   reloj       in   clock, rising edge
//   reset       in   synchronous active-high reset
//   mem_req     out  memory read request (PEDIR/ESPERAR)
//   mem_addr    out  read address, always pc
//   mem_ack     in   read done, mem_data valid this cycle
//   mem_data    in   instruction word from memory
//   instr       out  captured instruction word
//   opcode      out  upper 6 bits of instr
//   instr_valid out  instr holds an unconsumed instruction
//   instr_ready in   control unit consumes instr this cycle
//   s_inc       in   next-pc select on consume: 1 = pc+1, 0 = dir_salto
//   dir_salto   in   jump target
//   pc          out  program counter
//   parado      out  fetch stopped on halt opcode
module unidad_busqueda
    import unidad_busqueda_pkg::*;
#(
    parameter int unsigned              ANCHO_PC       = ANCHO_PC_DEF,
    parameter int unsigned              ANCHO_INSTR    = ANCHO_INSTR_DEF,
    parameter logic [ANCHO_OPCODE-1:0]  OPCODE_PARADA  = OPCODE_PARADA_DEF,
    parameter logic [ANCHO_OPCODE-1:0]  MASCARA_PARADA = MASCARA_PARADA_DEF
) (
    input  logic                    reloj,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [ANCHO_PC-1:0]     mem_addr,
    input  logic                    mem_ack,
    input  logic [ANCHO_INSTR-1:0]  mem_data,
    output logic [ANCHO_INSTR-1:0]  instr,
    output logic [5:0]              opcode,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    input  logic                    s_inc,
    input  logic [ANCHO_PC-1:0]     dir_salto,
    output logic [ANCHO_PC-1:0]     pc,
    output logic                    parado
);

    estado_e                 estado_q, estado_d;
    logic [ANCHO_INSTR-1:0]  instr_q, instr_d;
    logic [ANCHO_PC-1:0]     pc_w;
    logic                    consumo;
    logic                    parada;
    logic                    pc_en;
    logic                    pc_cargar;

    assign parada = es_parada(instr_q[ANCHO_INSTR-1 -: ANCHO_OPCODE], OPCODE_PARADA, MASCARA_PARADA);

    // State register
    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_q <= PEDIR;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            instr_q <= '0;
        end else begin
            instr_q <= instr_d;
        end
    end

    // Next state; the captured word only changes on an ack seen in ESPERAR,
    // so acks arriving in any other state are dropped.
    always_comb begin
        estado_d = estado_q;
        instr_d  = instr_q;
        case (estado_q)
            PEDIR: begin
                estado_d = ESPERAR;
            end
            ESPERAR: begin
                if (mem_ack) begin
                    instr_d  = mem_data;
                    estado_d = ENTREGAR;
                end
            end
            ENTREGAR: begin
                if (instr_ready) begin
                    estado_d = parada ? PARADO : PEDIR;
                end
            end
            PARADO: begin
                estado_d = PARADO;
            end
            default: begin
                estado_d = PEDIR;
            end
        endcase
    end

    // Outputs: handshake flags are pure decodes of the registered state.
    always_comb begin
        mem_req     = (estado_q == PEDIR) || (estado_q == ESPERAR);
        instr_valid = (estado_q == ENTREGAR);
        parado      = (estado_q == PARADO);
        consumo     = instr_valid && instr_ready;
        pc_en       = consumo && !parada;
        pc_cargar   = !s_inc;
    end

    contador_pc #(
        .ANCHO (ANCHO_PC)
    ) u_contador_pc (
        .reloj    (reloj),
        .reset    (reset),
        .en_i     (pc_en),
        .cargar_i (pc_cargar),
        .dir_i    (dir_salto),
        .pc_o     (pc_w)
    );

    assign pc       = pc_w;
    assign mem_addr = pc_w;
    assign instr    = instr_q;
    assign opcode   = instr_q[ANCHO_INSTR-1 -: ANCHO_OPCODE];

endmodule

// File: tb/tb_unidad_busqueda.sv
module tb_unidad_busqueda;

    logic        reloj = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        s_inc;
    logic [9:0]  dir_salto;
    logic [9:0]  pc;
    logic        parado;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    unidad_busqueda #(
        .ANCHO_PC    (10),
        .ANCHO_INSTR (16)
    ) dut (
        .reloj       (reloj),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .s_inc       (s_inc),
        .dir_salto   (dir_salto),
        .pc          (pc),
        .parado      (parado)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] data;
        logic        rdy;
        logic        inc;
        logic [9:0]  dir;
        logic        creq;   // compare mem_req for this vector
        logic        ereq;
        logic [9:0]  epc;
        logic        eval;
        logic [15:0] eins;
        logic        epar;
    } vec_t;

    vec_t vec[14];

    function automatic vec_t mk(logic rst, logic ack, logic [15:0] data, logic rdy, logic inc,
                                logic [9:0] dir, logic creq, logic ereq, logic [9:0] epc,
                                logic eval, logic [15:0] eins, logic epar);
        vec_t v;
        v.rst = rst; v.ack = ack; v.data = data; v.rdy = rdy; v.inc = inc; v.dir = dir;
        v.creq = creq; v.ereq = ereq; v.epc = epc; v.eval = eval; v.eins = eins; v.epar = epar;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    // From PEDIR: one cycle to ESPERAR, then ack with the word on its first cycle.
    task automatic fetch_word(input logic [15:0] w);
        mem_ack = 1'b0;
        tick();
        mem_ack  = 1'b1;
        mem_data = w;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        int unsigned cnt_req;
        logic [15:0] ins_cap;
        logic [15:0] w;

        reset = 1'b1; mem_ack = 1'b0; mem_data = '0;
        instr_ready = 1'b0; s_inc = 1'b1; dir_salto = '0;

        //          rst ack data      rdy inc dir     creq req pc      val ins       par
        vec[0]  = mk(1, 0, 16'h0000, 0, 1, 10'h000, 0, 0, 10'h000, 0, 16'h0000, 0);
        vec[1]  = mk(0, 0, 16'h0000, 1, 1, 10'h000, 1, 1, 10'h000, 0, 16'h0000, 0);
        vec[2]  = mk(0, 1, 16'h0400, 0, 1, 10'h000, 1, 0, 10'h000, 1, 16'h0400, 0);
        vec[3]  = mk(0, 0, 16'h0000, 1, 1, 10'h000, 1, 1, 10'h001, 0, 16'h0400, 0);
        vec[4]  = mk(0, 0, 16'h0000, 1, 1, 10'h000, 1, 1, 10'h001, 0, 16'h0400, 0);
        vec[5]  = mk(0, 1, 16'h0800, 1, 1, 10'h000, 1, 0, 10'h001, 1, 16'h0800, 0);
        vec[6]  = mk(0, 0, 16'h0000, 1, 1, 10'h000, 1, 1, 10'h002, 0, 16'h0800, 0);
        vec[7]  = mk(0, 0, 16'h0000, 0, 1, 10'h000, 1, 1, 10'h002, 0, 16'h0800, 0);
        vec[8]  = mk(0, 1, 16'h1234, 0, 1, 10'h000, 1, 0, 10'h002, 1, 16'h1234, 0);
        vec[9]  = mk(0, 0, 16'h0000, 1, 0, 10'h155, 1, 1, 10'h155, 0, 16'h1234, 0);
        vec[10] = mk(0, 0, 16'h0000, 0, 1, 10'h000, 1, 1, 10'h155, 0, 16'h1234, 0);
        vec[11] = mk(0, 1, 16'hF000, 1, 1, 10'h000, 1, 0, 10'h155, 1, 16'hF000, 0);
        vec[12] = mk(0, 1, 16'hFFFF, 0, 1, 10'h000, 1, 0, 10'h155, 1, 16'hF000, 0);
        vec[13] = mk(0, 0, 16'h0000, 1, 1, 10'h000, 1, 1, 10'h156, 0, 16'hF000, 0);

        for (int i = 0; i < 14; i++) begin
            reset = vec[i].rst; mem_ack = vec[i].ack; mem_data = vec[i].data;
            instr_ready = vec[i].rdy; s_inc = vec[i].inc; dir_salto = vec[i].dir;
            tick();
            if (vec[i].creq) chk($sformatf("v%0d mem_req", i), mem_req, vec[i].ereq);
            chk($sformatf("v%0d pc", i), pc, vec[i].epc);
            chk($sformatf("v%0d mem_addr", i), mem_addr, vec[i].epc);
            chk($sformatf("v%0d instr_valid", i), instr_valid, vec[i].eval);
            chk($sformatf("v%0d instr", i), instr, vec[i].eins);
            w = vec[i].eins;
            chk($sformatf("v%0d opcode", i), opcode, w[15:10]);
            chk($sformatf("v%0d parado", i), parado, vec[i].epar);
        end
        instr_ready = 1'b0; mem_ack = 1'b0; s_inc = 1'b1; dir_salto = '0;

        // pc wrap: jump to 0x3FF, then increment to 0
        fetch_word(16'h0100);
        instr_ready = 1'b1; s_inc = 1'b0; dir_salto = 10'h3FF;
        tick();
        instr_ready = 1'b0; s_inc = 1'b1; dir_salto = '0;
        chk("jump pc", pc, 10'h3FF);
        chk("jump mem_addr", mem_addr, 10'h3FF);
        fetch_word(16'h0200);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap pc", pc, 10'h000);
        chk("wrap mem_addr", mem_addr, 10'h000);
        chk("wrap mem_req", mem_req, 1'b1);

        // slow memory (ack on 5th ESPERAR cycle) and a stalled consumer
        cnt_req = mem_req ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req) cnt_req++;
        end
        mem_ack = 1'b1; mem_data = 16'h1C3A;
        tick();
        mem_ack = 1'b0; mem_data = 16'h5555;
        chk("slow req cycles", cnt_req, 6);
        chk("slow req drop", mem_req, 1'b0);
        ins_cap = 16'h1C3A;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall%0d instr", i), instr, ins_cap);
            chk($sformatf("stall%0d pc", i), pc, 10'h000);
            chk($sformatf("stall%0d valid", i), instr_valid, 1'b1);
            chk($sformatf("stall%0d mem_req", i), mem_req, 1'b0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("stall consume pc", pc, 10'h001);

        // halt on 0xE800, acks ignored afterwards
        fetch_word(16'hE800);
        chk("halt opcode", opcode, 6'b111010);
        instr_ready = 1'b1; s_inc = 1'b0; dir_salto = 10'h2AA;
        tick();
        chk("halt parado", parado, 1'b1);
        chk("halt pc", pc, 10'h001);
        chk("halt valid", instr_valid, 1'b0);
        cnt_req = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = (i % 2 == 0); mem_data = 16'h0400;
            tick();
            if (mem_req) cnt_req++;
        end
        mem_ack = 1'b0; instr_ready = 1'b0; s_inc = 1'b1; dir_salto = '0;
        chk("halt req cycles", cnt_req, 0);
        chk("halt parado held", parado, 1'b1);
        chk("halt pc held", pc, 10'h001);
        chk("halt instr held", instr, 16'hE800);

        // reset from halt, then reset in ESPERAR colliding with mem_ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst parado", parado, 1'b0);
        chk("rst pc", pc, 10'h000);
        fetch_word(16'h0400);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        chk("pre-rst mem_addr", mem_addr, 10'h001);
        chk("pre-rst valid", instr_valid, 1'b0);
        reset = 1'b1; mem_ack = 1'b1; mem_data = 16'hABCD;
        tick();
        reset = 1'b0;
        chk("rst+ack instr", instr, 16'h0000);
        chk("rst+ack valid", instr_valid, 1'b0);
        chk("rst+ack pc", pc, 10'h000);
        chk("rst+ack mem_req", mem_req, 1'b1);
        chk("rst+ack mem_addr", mem_addr, 10'h000);
        tick();  // ack still high while in PEDIR: must not be taken
        chk("late ack instr", instr, 16'h0000);
        chk("late ack valid", instr_valid, 1'b0);
        mem_data = 16'hEC00;
        tick();
        mem_ack = 1'b0;
        chk("esperar ack instr", instr, 16'hEC00);
        chk("esperar ack valid", instr_valid, 1'b1);
        // opcode 111011: low two bits are don't-care in the halt pattern
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("dc halt parado", parado, 1'b1);
        chk("dc halt pc", pc, 10'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unidad_busqueda.md
UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 Parameter: ANCHO_PC, default 10, program counter and instruction-memory address width.
REQ-002 Parameter: ANCHO_INSTR, default 16, instruction word width; opcode is bits [ANCHO_INSTR-1 : ANCHO_INSTR-6].
REQ-003 Parameter: OPCODE_PARADA, default 6'b1110??, opcode pattern (bits [1:0] don't-care) that stops fetching.
REQ-004 reloj  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req  out  1  instruction memory read request, held until acknowledged.
REQ-007 mem_addr  out  ANCHO_PC  read address; equals pc while mem_req=1.
REQ-008 mem_ack  in  1  memory read done; mem_data valid in the same cycle.
REQ-009 mem_data  in  ANCHO_INSTR  instruction word from memory.
REQ-010 instr  out  ANCHO_INSTR  captured instruction word presented to the control unit.
REQ-011 opcode  out  6  upper 6 bits of instr.
REQ-012 instr_valid  out  1  instr/opcode hold a fetched, not-yet-consumed instruction.
REQ-013 instr_ready  in  1  control unit consumes instr this cycle.
REQ-014 s_inc  in  1  next-PC select, sampled on consume: 1 = pc+1, 0 = dir_salto.
REQ-015 dir_salto  in  ANCHO_PC  jump target, sampled on consume when s_inc=0.
REQ-016 pc  out  ANCHO_PC  current program counter.
REQ-017 parado  out  1  fetch stopped on OPCODE_PARADA.

Function
REQ-018 FSM states PEDIR, ESPERAR, ENTREGAR, PARADO; exactly one active per cycle.
REQ-019 PEDIR: mem_req=1, mem_addr=pc; next state ESPERAR unconditionally.
REQ-020 ESPERAR: mem_req=1; on mem_ack=1, instr<=mem_data, next ENTREGAR; else stay; no timeout.
REQ-021 mem_ack while state is ENTREGAR or PARADO shall be ignored (no capture, no state change).
REQ-022 ENTREGAR: instr_valid=1, mem_req=0; instr and opcode stable until consumed.
REQ-023 Consume = instr_valid & instr_ready; instr_ready while instr_valid=0 has no effect.
REQ-024 On consume with opcode not matching OPCODE_PARADA: pc <= s_inc ? pc+1 : dir_salto, next PEDIR.
REQ-025 pc+1 wraps modulo 2^ANCHO_PC (all-ones -> 0); no flag raised.
REQ-026 On consume with opcode matching OPCODE_PARADA: pc unchanged, next PARADO, s_inc/dir_salto ignored.
REQ-027 PARADO: parado=1, mem_req=0, instr_valid=0; remain until reset.
REQ-028 Latency: mem_ack in cycle N -> instr_valid=1 in cycle N+1; minimum 3 cycles from PEDIR entry to instr_valid.
REQ-029 Throughput: at most one instruction per 3 cycles with zero-wait memory and instr_ready held high.
REQ-030 instr_valid, mem_req, parado are registered state decodes, free of combinational paths from inputs.

Reset
REQ-031 reset=1 at a rising edge: state<=PEDIR, pc<=0, instr<=0, instr_valid=0, mem_req=0 during reset cycle, parado=0.
REQ-032 reset dominates every simultaneous event (mem_ack, consume, halt) in the same cycle.
REQ-033 reset mid-fetch (ESPERAR) abandons the request; a late mem_ack after reset release is taken only if state is ESPERAR.
REQ-034 First cycle after reset release is PEDIR with mem_addr=0.

Structure
REQ-035 Shared package holds FSM state encoding, ANCHO_PC/ANCHO_INSTR defaults, OPCODE_PARADA, and opcode field positions, shared with the control unit.
REQ-036 One sub-module: contador_pc (ANCHO_PC register with synchronous reset, load-or-increment select, enable).

Verification
REQ-037 Reset, memory acks on first cycle of ESPERAR with words 0x0400,0x0800, instr_ready=1, s_inc=1 -> mem_addr 0,1,2; instr_valid every 3rd cycle; opcode 000001 then 000010.
REQ-038 Consume with s_inc=0, dir_salto=0x155 -> next mem_addr=0x155, pc=0x155.
REQ-039 pc=0x3FF, s_inc=1 consume -> pc=0x000, next fetch at address 0.
REQ-040 mem_ack delayed 5 cycles, instr_ready low 4 cycles after capture -> mem_req high 6 cycles then low, instr held constant, no pc change until consume.
REQ-041 Fetch 0xE800 (opcode 111010), consume -> parado=1, pc unchanged, mem_req stays 0 for 20 cycles despite mem_ack pulses.
REQ-042 reset asserted in ESPERAR coincident with mem_ack -> instr=0, instr_valid=0, pc=0, next cycle mem_req=1, mem_addr=0.
